// File: rtl/taxi_fare_meter.sv
// taxi_fare_meter: trip/fare engine counting 100 m wheel ticks and waiting seconds into a 0.1-yuan fare
//   Optional feature macro: TAXI_NIGHT_RATE_EN (adds the night input and a per-tick surcharge)
//   Ports:
//     sys_clk      clock
//     sys_rst_n    asynchronous active-low reset
//     run_flag     service level, rising edge starts a trip, falling edge ends it
//     wheel_pulse  one-cycle pulse per 100 m travelled
//     night        (TAXI_NIGHT_RATE_EN only) night-rate level
//     fare         accumulated fare, 0.1-yuan units, saturating
//     distance     ticks this trip, saturating
//     wait_sec     seconds spent waiting this trip, saturating
//     state        IDLE=0 RUN=1 WAIT=2 HOLD=3
//     trip_done    one-cycle pulse when a trip ends
module taxi_fare_meter #(
    parameter logic [24:0] CNT_1S       = 25'd19_999_999,
    parameter logic [15:0] BASE_FARE    = 16'd100,
    parameter logic [15:0] BASE_DIST    = 16'd30,
    parameter logic [15:0] UNIT_FARE    = 16'd2,
    parameter logic [7:0]  WAIT_START_S = 8'd10,
    parameter logic [7:0]  WAIT_UNIT_S  = 8'd60,
    parameter logic [15:0] WAIT_FARE    = 16'd5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        run_flag,
    input  logic        wheel_pulse,
`ifdef TAXI_NIGHT_RATE_EN
    input  logic        night,
`endif
    output logic [15:0] fare,
    output logic [15:0] distance,
    output logic [15:0] wait_sec,
    output logic [1:0]  state,
    output logic        trip_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_t;
    state_t      state_q, state_d;
    logic [15:0] fare_q, fare_d, distance_q, distance_d, wait_sec_q, wait_sec_d;
    logic [24:0] sec_cnt_q, sec_cnt_d;
    logic [7:0]  idle_sec_q, idle_sec_d, wait_unit_q, wait_unit_d, wait_unit_nx;
    logic        run_flag_q, run_flag_d, trip_done_q, trip_done_d;
    logic        rise, fall, active, tick;
    logic [16:0] unit_chg;
    logic [17:0] add;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [17:0] b);
        logic [18:0] s;
        s = {3'b0, a} + {1'b0, b};
        return (|s[18:16]) ? 16'hFFFF : s[15:0];
    endfunction

`ifdef TAXI_NIGHT_RATE_EN
    localparam logic [15:0] NIGHT_EXTRA = 16'd1;
    assign unit_chg = {1'b0, UNIT_FARE} + (night ? {1'b0, NIGHT_EXTRA} : 17'd0);
`else
    assign unit_chg = {1'b0, UNIT_FARE};
`endif

    assign rise         = run_flag & ~run_flag_q;
    assign fall         = ~run_flag & run_flag_q;
    assign active       = (state_q == RUN) || (state_q == WAIT);
    assign tick         = active && (sec_cnt_q == CNT_1S);
    assign wait_unit_nx = wait_unit_q + 8'd1;

    always_comb begin
        run_flag_d  = run_flag;
        state_d     = state_q;
        fare_d      = fare_q;
        distance_d  = distance_q;
        wait_sec_d  = wait_sec_q;
        sec_cnt_d   = sec_cnt_q;
        idle_sec_d  = idle_sec_q;
        wait_unit_d = wait_unit_q;
        trip_done_d = 1'b0;
        add         = 18'd0;
        if (rise) begin
            state_d     = RUN;
            fare_d      = BASE_FARE;
            distance_d  = 16'd0;
            wait_sec_d  = 16'd0;
            sec_cnt_d   = 25'd0;
            idle_sec_d  = 8'd0;
            wait_unit_d = 8'd0;
        end else if (fall && active) begin
            state_d     = HOLD;
            trip_done_d = 1'b1;
        end else if (active) begin
            sec_cnt_d = tick ? 25'd0 : sec_cnt_q + 25'd1;
            if (wheel_pulse) begin
                distance_d = sat_add(distance_q, 18'd1);
                add        = (distance_d > BASE_DIST) ? {1'b0, unit_chg} : 18'd0;
                idle_sec_d = 8'd0;
                if (state_q == WAIT) state_d = RUN;
            end else if (state_q == RUN && tick) begin
                idle_sec_d = idle_sec_q + 8'd1;
                if (idle_sec_d == WAIT_START_S) state_d = WAIT;
            end
            // waiting time keeps accruing in the cycle a pulse pulls us back to RUN
            if (state_q == WAIT && tick) begin
                wait_sec_d  = sat_add(wait_sec_q, 18'd1);
                wait_unit_d = (wait_unit_nx == WAIT_UNIT_S) ? 8'd0 : wait_unit_nx;
                if (wait_unit_nx == WAIT_UNIT_S) add = add + {2'b0, WAIT_FARE};
            end
            fare_d = sat_add(fare_q, add);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            fare_q      <= 16'd0;
            distance_q  <= 16'd0;
            wait_sec_q  <= 16'd0;
            sec_cnt_q   <= 25'd0;
            idle_sec_q  <= 8'd0;
            wait_unit_q <= 8'd0;
            run_flag_q  <= 1'b0;
            trip_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fare_q      <= fare_d;
            distance_q  <= distance_d;
            wait_sec_q  <= wait_sec_d;
            sec_cnt_q   <= sec_cnt_d;
            idle_sec_q  <= idle_sec_d;
            wait_unit_q <= wait_unit_d;
            run_flag_q  <= run_flag_d;
            trip_done_q <= trip_done_d;
        end
    end

    assign fare      = fare_q;
    assign distance  = distance_q;
    assign wait_sec  = wait_sec_q;
    assign state     = state_q;
    assign trip_done = trip_done_q;
endmodule

// File: tb/tb_taxi_fare_meter.sv
// tb_taxi_fare_meter: randomized and directed checks of two meters (default and huge unit fare) against a trip-level model
module tb_taxi_fare_meter;
    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, run_flag = 1'b0, wheel_pulse = 1'b0, night = 1'b0;
    logic [15:0] fare0, distance0, wait_sec0, fare1, distance1, wait_sec1;
    logic [1:0]  state0, state1;
    logic        trip_done0, trip_done1;
    int          n_chk = 0, n_fail = 0;

`ifdef TAXI_NIGHT_RATE_EN
    localparam int NE = 1;
`else
    localparam int NE = 0;
`endif
    localparam int SEC = 10, WSTART = 3, WUNIT = 2, BASE = 100, BDIST = 30, WFARE = 5;
    int unit_p[2] = '{2, 32'h4000};

    // trip-level model: one entry per meter
    int m_state[2], m_fare[2], m_dist[2], m_wsec[2], m_phase[2], m_idle[2], m_wu[2], m_td[2];
    int m_prev_run;

    always #5 sys_clk = ~sys_clk;

    taxi_fare_meter #(.CNT_1S(25'd9), .WAIT_START_S(8'd3), .WAIT_UNIT_S(8'd2)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run_flag(run_flag), .wheel_pulse(wheel_pulse),
`ifdef TAXI_NIGHT_RATE_EN
        .night(night),
`endif
        .fare(fare0), .distance(distance0), .wait_sec(wait_sec0), .state(state0), .trip_done(trip_done0));

    taxi_fare_meter #(.CNT_1S(25'd9), .WAIT_START_S(8'd3), .WAIT_UNIT_S(8'd2), .UNIT_FARE(16'h4000)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .run_flag(run_flag), .wheel_pulse(wheel_pulse),
`ifdef TAXI_NIGHT_RATE_EN
        .night(night),
`endif
        .fare(fare1), .distance(distance1), .wait_sec(wait_sec1), .state(state1), .trip_done(trip_done1));

    function automatic int mn(input int a);
        return a > 65535 ? 65535 : a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_fare[i] = 0; m_dist[i] = 0; m_wsec[i] = 0;
            m_phase[i] = 0; m_idle[i] = 0; m_wu[i] = 0; m_td[i] = 0;
        end
        m_prev_run = 0;
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit rise, fall, active, sec_done;
            int inc, nxt;
            rise     = run_flag && m_prev_run == 0;
            fall     = !run_flag && m_prev_run == 1;
            active   = m_state[i] == 1 || m_state[i] == 2;
            sec_done = active && m_phase[i] == SEC - 1;
            m_td[i]  = 0;
            if (rise) begin
                m_state[i] = 1; m_fare[i] = BASE; m_dist[i] = 0; m_wsec[i] = 0;
                m_phase[i] = 0; m_idle[i] = 0; m_wu[i] = 0;
            end else if (fall && active) begin
                m_state[i] = 3; m_td[i] = 1;
            end else if (active) begin
                inc = 0;
                nxt = m_state[i];
                m_phase[i] = sec_done ? 0 : m_phase[i] + 1;
                if (wheel_pulse) begin
                    m_dist[i] = mn(m_dist[i] + 1);
                    if (m_dist[i] > BDIST) inc += unit_p[i] + (night ? NE : 0);
                    m_idle[i] = 0;
                    nxt = 1;
                end else if (m_state[i] == 1 && sec_done) begin
                    m_idle[i]++;
                    if (m_idle[i] == WSTART) nxt = 2;
                end
                if (m_state[i] == 2 && sec_done) begin
                    m_wsec[i] = mn(m_wsec[i] + 1);
                    m_wu[i]++;
                    if (m_wu[i] == WUNIT) begin m_wu[i] = 0; inc += WFARE; end
                end
                m_fare[i] = mn(m_fare[i] + inc);
                m_state[i] = nxt;
            end
        end
        m_prev_run = run_flag;
    endtask

    function automatic logic [50:0] act(input int i);
        return i == 0 ? {fare0, distance0, wait_sec0, state0, trip_done0}
                      : {fare1, distance1, wait_sec1, state1, trip_done1};
    endfunction

    function automatic logic [50:0] expv(input int i);
        return {16'(m_fare[i]), 16'(m_dist[i]), 16'(m_wsec[i]), 2'(m_state[i]), 1'(m_td[i])};
    endfunction

    task automatic step();
        model_step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic new_trip();
        wheel_pulse = 0;
        run_flag = 0; step();
        run_flag = 1; step();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (act(i) !== 51'd0) begin n_fail++; $display("FAIL reset[%0d] got=%h want=0", i, act(i)); end
        end
        sys_rst_n = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (act(i) !== expv(i)) begin n_fail++; $display("FAIL idle[%0d] got=%h want=%h", i, act(i), expv(i)); end
        end
    endtask

    task automatic test_start();
        run_flag = 1;
        step();
        n_chk++;
        if ({state0, fare0, distance0, trip_done0} !== {2'd1, 16'd100, 16'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL start got st=%0d fare=%0d dist=%0d td=%b want st=1 fare=100 dist=0 td=0", state0, fare0, distance0, trip_done0);
        end
    endtask

    task automatic test_distance();
        wheel_pulse = 1;
        for (int p = 1; p <= 35; p++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (act(i) !== expv(i)) begin n_fail++; $display("FAIL dist_p%0d[%0d] got=%h want=%h", p, i, act(i), expv(i)); end
            end
            if (p == 30) begin
                n_chk++;
                if (fare0 !== 16'd100) begin n_fail++; $display("FAIL base_cover got=%0d want=100", fare0); end
            end
        end
        wheel_pulse = 0;
        n_chk++;
        if ({distance0, fare0} !== {16'd35, 16'd110}) begin
            n_fail++; $display("FAIL dist35 got dist=%0d fare=%0d want dist=35 fare=110", distance0, fare0);
        end
    endtask

    task automatic test_wait();
        int f0, cyc;
        cyc = 0;
        while (state0 !== 2'd2 && cyc < 60) begin
            step(); cyc++;
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (act(i) !== expv(i)) begin n_fail++; $display("FAIL to_wait[%0d] got=%h want=%h", i, act(i), expv(i)); end
            end
        end
        n_chk++;
        if (state0 !== 2'd2) begin n_fail++; $display("FAIL wait_entry got st=%0d want st=2 within 60 cycles", state0); end
        f0 = fare0;
        repeat (4 * SEC) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (act(i) !== expv(i)) begin n_fail++; $display("FAIL waiting[%0d] got=%h want=%h", i, act(i), expv(i)); end
            end
        end
        n_chk++;
        if ({wait_sec0, fare0} !== {16'd4, 16'(f0 + 10)}) begin
            n_fail++; $display("FAIL wait_fare got ws=%0d fare=%0d want ws=4 fare=%0d", wait_sec0, fare0, f0 + 10);
        end
        wheel_pulse = 1; step(); wheel_pulse = 0;
        n_chk++;
        if (state0 !== 2'd1) begin n_fail++; $display("FAIL wait_exit got st=%0d want 1", state0); end
    endtask

    task automatic test_trip_end();
        logic [15:0] f;
        run_flag = 0; step();
        n_chk++;
        if ({state0, trip_done0} !== {2'd3, 1'b1}) begin
            n_fail++; $display("FAIL trip_end got st=%0d td=%b want st=3 td=1", state0, trip_done0);
        end
        f = fare0;
        wheel_pulse = 1;
        repeat (5) begin
            step();
            n_chk++;
            if ({fare0, trip_done0, state0} !== {f, 1'b0, 2'd3}) begin
                n_fail++; $display("FAIL hold got fare=%0d td=%b st=%0d want fare=%0d td=0 st=3", fare0, trip_done0, state0, f);
            end
        end
        wheel_pulse = 0; run_flag = 1; step();
        n_chk++;
        if ({state0, fare0} !== {2'd1, 16'd100}) begin
            n_fail++; $display("FAIL restart got st=%0d fare=%0d want st=1 fare=100", state0, fare0);
        end
    endtask

    task automatic test_night();
        new_trip();
        night = 1; wheel_pulse = 1;
        repeat (32) step();
        night = 0; wheel_pulse = 0;
        n_chk++;
        if (fare0 !== 16'(NE ? 106 : 104)) begin
            n_fail++; $display("FAIL night got fare=%0d want %0d", fare0, NE ? 106 : 104);
        end
    endtask

    task automatic test_random();
        repeat (3000) begin
            wheel_pulse = ($urandom_range(7) == 0);
            night       = $urandom_range(1);
            if ($urandom_range(149) == 0) run_flag = ~run_flag;
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (act(i) !== expv(i)) begin n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, act(i), expv(i)); end
            end
        end
        night = 0; wheel_pulse = 0;
    endtask

    task automatic test_saturation();
        new_trip();
        wheel_pulse = 1;
        repeat (34) begin
            step();
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (act(i) !== expv(i)) begin n_fail++; $display("FAIL sat_run[%0d] got=%h want=%h", i, act(i), expv(i)); end
            end
        end
        wheel_pulse = 0;
        n_chk++;
        if (fare1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat got fare=%h want FFFF", fare1); end
        sys_rst_n = 0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (act(i) !== 51'd0) begin n_fail++; $display("FAIL abort[%0d] got=%h want=0", i, act(i)); end
        end
        @(negedge sys_clk);
        sys_rst_n = 1;
        step();
        n_chk++;
        if ({state0, fare0} !== {2'd1, 16'd100}) begin
            n_fail++; $display("FAIL rst_release_rise got st=%0d fare=%0d want st=1 fare=100", state0, fare0);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_distance();
        test_wait();
        test_trip_end();
        test_night();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
